// File: rtl/fir_loader_pkg.sv
// Shared filter package: loader FSM state encoding and filter geometry defaults.
package fir_loader_pkg;

    localparam int unsigned FirW1     = 9;
    localparam int unsigned FirNcoef  = 3;
    localparam int unsigned FirNflush = 3;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StRun,
        StFlush
    } fir_state_e;

endpackage

// File: rtl/fir_loader.sv
// Drives the filter pins: streams coefficients into the tap chain, then samples,
// then a run of zero samples to flush the delay line. All outputs are registered.
module fir_loader
    import fir_loader_pkg::*;
#(
    parameter int unsigned W1     = FirW1,
    parameter int unsigned NCOEF  = FirNcoef,
    parameter int unsigned NFLUSH = FirNflush
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          start_load_i,
    input  logic          stop_i,
    input  logic          cfg_valid_i,
    input  logic [W1-1:0] cfg_coef_i,
    output logic          cfg_ready_o,
    input  logic          smp_valid_i,
    input  logic [W1-1:0] smp_data_i,
    output logic          smp_ready_o,
    output logic          load_x_o,
    output logic [W1-1:0] c_out_o,
    output logic [W1-1:0] x_out_o,
    output logic          loaded_o,
    output logic [7:0]    underrun_cnt_o
);

    localparam int unsigned BeatW  = $clog2(NCOEF + 1);
    localparam int unsigned FlushW = $clog2(NFLUSH + 1);

    fir_state_e        state_q, state_d;
    logic [BeatW-1:0]  beat_cnt_q, beat_cnt_d;
    logic [FlushW-1:0] flush_cnt_q, flush_cnt_d;
    logic              cfg_ready_q, cfg_ready_d;
    logic              smp_ready_q, smp_ready_d;
    logic              load_x_q, load_x_d;
    logic [W1-1:0]     c_out_q, c_out_d;
    logic [W1-1:0]     x_out_q, x_out_d;
    logic              loaded_q, loaded_d;
    logic [7:0]        underrun_q, underrun_d;

    always_comb begin
        state_d     = state_q;
        beat_cnt_d  = beat_cnt_q;
        flush_cnt_d = flush_cnt_q;
        load_x_d    = 1'b1;
        c_out_d     = c_out_q;
        x_out_d     = x_out_q;
        loaded_d    = loaded_q;
        underrun_d  = underrun_q;

        unique case (state_q)
            StIdle: begin
                x_out_d = '0;
                if (start_load_i) begin
                    state_d    = StLoad;
                    beat_cnt_d = '0;
                    loaded_d   = 1'b0;
                end
            end
            StLoad: begin
                // Only an accepted beat pulses load_x low; idle LOAD cycles leave the chain alone.
                if (cfg_valid_i && cfg_ready_q) begin
                    load_x_d   = 1'b0;
                    c_out_d    = cfg_coef_i;
                    beat_cnt_d = beat_cnt_q + BeatW'(1);
                    if (beat_cnt_q == BeatW'(NCOEF - 1)) begin
                        state_d  = StRun;
                        loaded_d = 1'b1;
                    end
                end
            end
            StRun: begin
                if (stop_i) begin
                    // Stop wins over a sample offered in the same cycle.
                    state_d     = StFlush;
                    flush_cnt_d = '0;
                    x_out_d     = '0;
                end else if (smp_valid_i && smp_ready_q) begin
                    x_out_d = smp_data_i;
                end else begin
                    x_out_d = '0;
                    if (underrun_q != 8'hFF) begin
                        underrun_d = underrun_q + 8'd1;
                    end
                end
            end
            StFlush: begin
                x_out_d     = '0;
                flush_cnt_d = flush_cnt_q + FlushW'(1);
                if (flush_cnt_q == FlushW'(NFLUSH - 1)) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        cfg_ready_d = (state_d == StLoad);
        smp_ready_d = (state_d == StRun);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= StIdle;
            beat_cnt_q  <= '0;
            flush_cnt_q <= '0;
            cfg_ready_q <= 1'b0;
            smp_ready_q <= 1'b0;
            load_x_q    <= 1'b1;
            c_out_q     <= '0;
            x_out_q     <= '0;
            loaded_q    <= 1'b0;
            underrun_q  <= '0;
        end else begin
            state_q     <= state_d;
            beat_cnt_q  <= beat_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            cfg_ready_q <= cfg_ready_d;
            smp_ready_q <= smp_ready_d;
            load_x_q    <= load_x_d;
            c_out_q     <= c_out_d;
            x_out_q     <= x_out_d;
            loaded_q    <= loaded_d;
            underrun_q  <= underrun_d;
        end
    end

    assign cfg_ready_o    = cfg_ready_q;
    assign smp_ready_o    = smp_ready_q;
    assign load_x_o       = load_x_q;
    assign c_out_o        = c_out_q;
    assign x_out_o        = x_out_q;
    assign loaded_o       = loaded_q;
    assign underrun_cnt_o = underrun_q;

endmodule

// File: tb/tb_fir_loader.sv
// Bench for fir_loader: directed cycles push the expected next-cycle pin values into
// a scoreboard queue; a monitor pops and compares one entry after every rising edge.
module tb_fir_loader;

    localparam int W = 9;

    typedef struct {
        logic         lx;
        logic [W-1:0] c;
        logic [W-1:0] x;
        logic         cr;
        logic         sr;
        logic         ld;
        logic         chk_ur;
        logic [7:0]   ur;
    } exp_t;

    logic         clk;
    logic         reset;
    logic         start_load;
    logic         stop;
    logic         cfg_valid;
    logic [W-1:0] cfg_coef;
    logic         cfg_ready;
    logic         smp_valid;
    logic [W-1:0] smp_data;
    logic         smp_ready;
    logic         load_x;
    logic [W-1:0] c_out;
    logic [W-1:0] x_out;
    logic         loaded;
    logic [7:0]   underrun_cnt;

    exp_t exp_q[$];
    exp_t e;
    int   n_checks = 0;
    int   n_fail   = 0;

    fir_loader dut (
        .clk_i         (clk),
        .reset_i       (reset),
        .start_load_i  (start_load),
        .stop_i        (stop),
        .cfg_valid_i   (cfg_valid),
        .cfg_coef_i    (cfg_coef),
        .cfg_ready_o   (cfg_ready),
        .smp_valid_i   (smp_valid),
        .smp_data_i    (smp_data),
        .smp_ready_o   (smp_ready),
        .load_x_o      (load_x),
        .c_out_o       (c_out),
        .x_out_o       (x_out),
        .loaded_o      (loaded),
        .underrun_cnt_o(underrun_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, want, $time);
        end
    endtask

    task automatic drv(input logic rst, input logic sl, input logic stp, input logic cv,
                       input int cc, input logic sv, input int sd);
        @(negedge clk);
        reset      = rst;
        start_load = sl;
        stop       = stp;
        cfg_valid  = cv;
        cfg_coef   = cc[W-1:0];
        smp_valid  = sv;
        smp_data   = sd[W-1:0];
    endtask

    // Expected pins after the coming rising edge; ur < 0 skips the underrun check.
    task automatic exp_nx(input logic lx, input int c, input int x, input logic cr,
                          input logic sr, input logic ld, input int ur);
        exp_t n;
        n.lx     = lx;
        n.c      = c[W-1:0];
        n.x      = x[W-1:0];
        n.cr     = cr;
        n.sr     = sr;
        n.ld     = ld;
        n.chk_ur = (ur >= 0);
        n.ur     = ur[7:0];
        exp_q.push_back(n);
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check_eq("load_x", 32'(load_x), 32'(e.lx));
            check_eq("c_out", 32'(c_out), 32'(e.c));
            check_eq("x_out", 32'(x_out), 32'(e.x));
            check_eq("cfg_ready", 32'(cfg_ready), 32'(e.cr));
            check_eq("smp_ready", 32'(smp_ready), 32'(e.sr));
            check_eq("loaded", 32'(loaded), 32'(e.ld));
            if (e.chk_ur) check_eq("underrun_cnt", 32'(underrun_cnt), 32'(e.ur));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; start_load = 1'b0; stop = 1'b0; cfg_valid = 1'b0;
        cfg_coef = '0; smp_valid = 1'b0; smp_data = '0;

        // Reset state, and reset beating start_load and handshakes
        drv(1, 0, 0, 0, 0, 0, 0);   exp_nx(1, 0, 0, 0, 0, 0, 0);
        drv(1, 1, 0, 1, 5, 1, 9);   exp_nx(1, 0, 0, 0, 0, 0, 0);

        // Back-to-back load 5, -3, 7
        drv(0, 1, 0, 0, 0, 0, 0);   exp_nx(1, 0, 0, 1, 0, 0, 0);
        drv(0, 0, 0, 1, 5, 0, 0);   exp_nx(0, 5, 0, 1, 0, 0, 0);
        drv(0, 0, 0, 1, -3, 0, 0);  exp_nx(0, -3, 0, 1, 0, 0, 0);
        drv(0, 0, 0, 1, 7, 0, 0);   exp_nx(0, 7, 0, 0, 1, 1, 0);

        // Streaming; start_load and cfg_valid in RUN are ignored
        drv(0, 0, 0, 0, 0, 1, 10);  exp_nx(1, 7, 10, 0, 1, 1, 0);
        drv(0, 1, 0, 0, 0, 1, 20);  exp_nx(1, 7, 20, 0, 1, 1, 0);
        drv(0, 0, 0, 1, 9, 1, -30); exp_nx(1, 7, -30, 0, 1, 1, 0);

        // Stop with sample 99 offered, three flush cycles, then IDLE
        drv(0, 0, 1, 0, 0, 1, 99);  exp_nx(1, 7, 0, 0, 0, 1, 0);
        drv(0, 1, 1, 0, 0, 0, 0);   exp_nx(1, 7, 0, 0, 0, 1, 0);
        drv(0, 0, 0, 0, 0, 1, 55);  exp_nx(1, 7, 0, 0, 0, 1, 0);
        drv(0, 0, 0, 0, 0, 0, 0);   exp_nx(1, 7, 0, 0, 0, 1, 0);
        drv(0, 0, 1, 0, 0, 0, 0);   exp_nx(1, 7, 0, 0, 0, 1, 0);

        // Gapped load 1, 2, 3 with stray stop/sample in the gaps
        drv(0, 1, 0, 0, 0, 0, 0);   exp_nx(1, 7, 0, 1, 0, 0, 0);
        drv(0, 0, 0, 1, 1, 0, 0);   exp_nx(0, 1, 0, 1, 0, 0, 0);
        drv(0, 0, 1, 0, 77, 0, 0);  exp_nx(1, 1, 0, 1, 0, 0, 0);
        drv(0, 0, 0, 0, 77, 1, 44); exp_nx(1, 1, 0, 1, 0, 0, 0);
        drv(0, 0, 0, 1, 2, 0, 0);   exp_nx(0, 2, 0, 1, 0, 0, 0);
        drv(0, 0, 0, 0, 0, 0, 0);   exp_nx(1, 2, 0, 1, 0, 0, 0);
        drv(0, 0, 0, 0, 0, 0, 0);   exp_nx(1, 2, 0, 1, 0, 0, 0);
        drv(0, 0, 0, 1, 3, 0, 0);   exp_nx(0, 3, 0, 0, 1, 1, 0);

        // Underrun saturation over 300 idle RUN cycles
        for (int k = 1; k <= 300; k++) begin
            drv(0, 0, 0, 0, 0, 0, 0);
            exp_nx(1, 3, 0, 0, 1, 1, (k > 255) ? 255 : k);
        end
        drv(0, 0, 1, 0, 0, 0, 0);   exp_nx(1, 3, 0, 0, 0, 1, 255);
        for (int k = 0; k < 3; k++) begin
            drv(0, 0, 0, 0, 0, 0, 0);
            exp_nx(1, 3, 0, 0, 0, 1, 255);
        end

        // Reset after the second of three beats abandons the load
        drv(0, 1, 0, 0, 0, 0, 0);   exp_nx(1, 3, 0, 1, 0, 0, 255);
        drv(0, 0, 0, 1, 4, 0, 0);   exp_nx(0, 4, 0, 1, 0, 0, 255);
        drv(0, 0, 0, 1, 6, 0, 0);   exp_nx(0, 6, 0, 1, 0, 0, 255);
        drv(1, 0, 0, 1, 8, 0, 0);   exp_nx(1, 0, 0, 0, 0, 0, 0);
        drv(0, 0, 0, 1, 8, 0, 0);   exp_nx(1, 0, 0, 0, 0, 0, 0);
        drv(0, 0, 0, 0, 0, 0, 0);   exp_nx(1, 0, 0, 0, 0, 0, 0);

        // Reset mid-flush
        drv(0, 1, 0, 0, 0, 0, 0);   exp_nx(1, 0, 0, 1, 0, 0, 0);
        drv(0, 0, 0, 1, 11, 0, 0);  exp_nx(0, 11, 0, 1, 0, 0, 0);
        drv(0, 0, 0, 1, 12, 0, 0);  exp_nx(0, 12, 0, 1, 0, 0, 0);
        drv(0, 0, 0, 1, 13, 0, 0);  exp_nx(0, 13, 0, 0, 1, 1, 0);
        drv(0, 0, 1, 0, 0, 1, 21);  exp_nx(1, 13, 0, 0, 0, 1, 0);
        drv(1, 1, 0, 0, 0, 0, 0);   exp_nx(1, 0, 0, 0, 0, 0, 0);
        drv(0, 0, 0, 0, 0, 0, 0);   exp_nx(1, 0, 0, 0, 0, 0, 0);

        @(posedge clk);
        #2;
        check_eq("scoreboard_drain", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
